hamming_serial_rx: RTL and testbench
====================================

# hamming_serial_rx

- Parametrised serial Hamming receiver that generalises the fixed (7,4) serial corrector to any codeword size set by the parity-bit count.
- Shifts in one code bit per `strobe_in` and, once a frame is complete, computes the syndrome and corrects a single-bit error.
- Emits the data word with a one-cycle valid pulse and error status, and keeps a saturating corrected-frame counter.
- Sits between the serial link front end and the display/data consumer.

## Interface
Parameters:
- `P`, 3, parity-bit count, legal range 3..6.
- `CNT_W`, 8, width of the corrected-frame counter.

Derived values, not overridable:
- `N = 2^P - 1`, Hamming codeword length.
- `K = N - P`, data width.
- `F`, frame length: `N`, or `N+1` with SECDED.

Ports:
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `d_in` input 1: serial code bit.
- `strobe_in` input 1: `d_in` is sampled on any edge where this is high.
- `sync_in` input 1: frame resynchronisation; discards any partial frame.
- `d_out` output K: corrected data word.
- `d_valid` output 1: one-cycle pulse, `d_out` and status updated.
- `syndrome` output P: Hamming syndrome of the last frame.
- `err_corr` output 1: last frame had a corrected single error.
- `err_det` output 1: last frame had an uncorrectable double error (SECDED only, otherwise 0).
- `err_count` output CNT_W: saturating count of frames with `err_corr=1`.
- `busy` output 1: partial frame held (bit counter nonzero).

## Operation
- Bit order: the first bit received is codeword position 1, the N-th bit is position N. With SECDED, bit N+1 is the overall-parity bit.
- Parity bits sit at power-of-two positions.
- Data bits sit at the remaining positions, in ascending position order, mapped to `d_out[K-1]` down to `d_out[0]`.
  - P=3 mapping: positions 3,5,6,7 go to `d_out[3:0]`.
- Frame assembly:
  - A bit counter (width P+1) increments on each strobe.
  - The shift register takes `d_in` at the LSB.
  - On the strobe that delivers bit F, decode uses the shift register plus the incoming bit, and the counter returns to 0.
- Syndrome: XOR of the position indices of all 1-bits over positions 1..N.
  - syndrome 0: no correction.
  - Nonzero syndrome: the bit at that position is inverted before data extraction, and `err_corr=1`.
- SECDED adds an overall parity bit `pa`, the XOR of all F bits. Decode rules:
  - s=0, pa=0: clean.
  - s≠0, pa=1: correct position s, `err_corr=1`.
  - s=0, pa=1: parity bit itself in error; data untouched, `err_corr=1`.
  - s≠0, pa=0: `err_det=1`, `err_corr=0`, `d_out` is the raw uncorrected data.
- `err_count` increments on every `d_valid` with `err_corr=1` and saturates at all-ones. It is cleared only by `rst`.
- `sync_in`:
  - Clears the counter and discards held bits. No `d_valid` is produced for the discarded partial frame.
  - If `strobe_in` is high on the same edge, that bit becomes bit 1 of the new frame.
  - `sync_in` takes priority over frame completion: a completing strobe coinciding with `sync_in` starts a new frame and does not decode.

## Timing
- Reset values: `d_out=0`, `d_valid=0`, `syndrome=0`, `err_corr=0`, `err_det=0`, `err_count=0`, `busy=0`, bit counter 0.
- Latency: `d_out`, `syndrome` and the error flags are registered on the same edge that samples bit F.
  - `d_valid` is high for exactly the following cycle.
  - `err_count` reflects that frame in the same cycle.
- `d_out`, `syndrome`, `err_corr` and `err_det` hold until the next completed frame.
- Back-to-back frames: the strobe on the cycle right after completion is bit 1 of the next frame, so strobes may be continuous.
- `strobe_in` low: state frozen, no timeout.
- `rst` mid-frame: the partial frame is discarded and all outputs go to reset values on that edge. `rst` overrides `strobe_in` and `sync_in`.

## Configuration
- `HAMM_SECDED_EN` defined:
  - Frame length N+1; extended Hamming SECDED decode as above.
  - `err_det` is driven.
- `HAMM_SECDED_EN` undefined:
  - Frame length N; pure SEC.
  - `err_det` tied 0.
  - A double error is miscorrected silently.

## Test plan
- **Clean frame, P=3:** send 0,1,1,0,0,1,1 (plus 0 with SECDED).
  - `d_out=4'b1011`, `syndrome=0`, `err_corr=0`.
  - `d_valid` high one cycle after the edge sampling the last bit.
- **Single error at position 5:** send 0,1,1,0,1,1,1 (plus 0 with SECDED).
  - `syndrome=3'd5`, `d_out=4'b1011`, `err_corr=1`, `err_count` goes 0→1.
- **Double error (SECDED):** flip positions 2 and 6 of the clean frame, parity bit 0.
  - `syndrome=3'd4`, `err_det=1`, `err_corr=0`, `d_out=4'b1001` (raw), `err_count` unchanged.
- **Resync and gaps:** send 3 bits, pulse `sync_in` with `strobe_in`, then send the clean frame, with `strobe_in` low between some bits.
  - Exactly one `d_valid`, `d_out=4'b1011`.
  - `busy` falls after the last bit.
- **Saturation and back-to-back:** CNT_W=2, five consecutive single-error frames with continuous strobes.
  - Five `d_valid` pulses F cycles apart.
  - `err_count` reads 1,2,3,3,3.
- **Reset mid-frame, then P=4:** `rst` after 4 bits clears all outputs. Then a 15-bit frame with data 11'h5A3 and position 9 flipped.
  - `syndrome=4'd9`, `d_out=11'h5A3`.

Source files
------------

// File: rtl/hamming_serial_rx.sv
// -----------------------------------------------------------------------------
// hamming_serial_rx
//
// Parametrised serial Hamming receiver. Code bits arrive one per strobe_in,
// first bit = codeword position 1. When the frame completes, the syndrome is
// computed, a single-bit error is corrected and the data bits are extracted
// (ascending non-power-of-two positions map to d_out[K-1] .. d_out[0]).
//
// Build option:
//   HAMM_SECDED_EN  defined   -> frame length N+1, extended-Hamming SECDED
//                               decode, err_det driven.
//                   undefined -> frame length N, pure SEC, err_det tied 0.
//
// Parameters:
//   P      parity-bit count, legal range 3..6 (N = 2^P-1, K = N-P)
//   CNT_W  width of the saturating corrected-frame counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   d_in       serial code bit
//   strobe_in  sample d_in on this edge
//   sync_in    discard any partial frame; a coincident strobe starts bit 1
//   d_out      corrected data word (held until next frame)
//   d_valid    one-cycle pulse when d_out/status were updated
//   syndrome   Hamming syndrome of the last frame
//   err_corr   last frame had a corrected single error
//   err_det    last frame had an uncorrectable double error (SECDED only)
//   err_count  saturating count of frames with err_corr=1
//   busy       a partial frame is held
// -----------------------------------------------------------------------------
module hamming_serial_rx #(
    parameter int unsigned P     = 3,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned N    = (1 << P) - 1,
    localparam int unsigned K    = N - P
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_in,
    input  logic             strobe_in,
    input  logic             sync_in,
    output logic [K-1:0]     d_out,
    output logic             d_valid,
    output logic [P-1:0]     syndrome,
    output logic             err_corr,
    output logic             err_det,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

`ifdef HAMM_SECDED_EN
    localparam int unsigned F  = N + 1;
`else
    localparam int unsigned F  = N;
`endif
    localparam int unsigned CW = P + 1;   // bit counter width
    localparam int unsigned SW = F - 1;   // bits held before the completing one

    // ---------------------------------------------------------------- state
    logic [CW-1:0]    bit_cnt_q,   bit_cnt_d;
    logic [SW-1:0]    shreg_q,     shreg_d;
    logic [K-1:0]     d_out_q,     d_out_d;
    logic             d_valid_q,   d_valid_d;
    logic [P-1:0]     syndrome_q,  syndrome_d;
    logic             err_corr_q,  err_corr_d;
    logic             err_det_q,   err_det_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             busy_q,      busy_d;

    // ---------------------------------------------------------------- decode
    logic [F-1:0] frame_c;
    logic [N:1]   cw_c;
    logic [N:1]   fixed_c;
    logic [P-1:0] syn_c;
    logic [K-1:0] data_c;
    logic         flip_c;
    logic         corr_c;
    logic         det_c;
`ifdef HAMM_SECDED_EN
    logic         pa_c;
`endif

    // Frame as it stands including the bit arriving on this edge; first bit at MSB.
    always_comb begin
        frame_c = {shreg_q, d_in};
        for (int unsigned p = 1; p <= N; p++) begin
            cw_c[p] = frame_c[F - p];
        end
    end

    // Syndrome: XOR of the indices of all set positions.
    always_comb begin
        syn_c = '0;
        for (int unsigned p = 1; p <= N; p++) begin
            if (cw_c[p]) begin
                syn_c = syn_c ^ P'(p);
            end
        end
    end

    // Correction decision.
    always_comb begin
        flip_c = 1'b0;
        corr_c = 1'b0;
        det_c  = 1'b0;
`ifdef HAMM_SECDED_EN
        pa_c = ^frame_c;
        if (syn_c != '0) begin
            if (pa_c) begin
                flip_c = 1'b1;
                corr_c = 1'b1;
            end else begin
                // Two errors: report, leave data raw.
                det_c = 1'b1;
            end
        end else if (pa_c) begin
            // Only the overall parity bit was hit; data is intact.
            corr_c = 1'b1;
        end
`else
        if (syn_c != '0) begin
            flip_c = 1'b1;
            corr_c = 1'b1;
        end
`endif
    end

    // Invert the flagged position, then gather data bits in ascending order.
    always_comb begin
        int unsigned j;
        fixed_c = cw_c;
        data_c  = '0;
        j       = K;
        for (int unsigned p = 1; p <= N; p++) begin
            fixed_c[p] = cw_c[p] ^ (flip_c && (syn_c == P'(p)));
        end
        for (int unsigned p = 1; p <= N; p++) begin
            if ((p & (p - 1)) != 0) begin
                j         = j - 1;
                data_c[j] = fixed_c[p];
            end
        end
    end

    // ---------------------------------------------------------------- control
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        d_out_d     = d_out_q;
        d_valid_d   = 1'b0;
        syndrome_d  = syndrome_q;
        err_corr_d  = err_corr_q;
        err_det_d   = err_det_q;
        err_count_d = err_count_q;

        if (sync_in) begin
            // Resync wins over completion; a coincident strobe is bit 1.
            bit_cnt_d = strobe_in ? CW'(1) : '0;
            shreg_d   = strobe_in ? SW'(d_in) : '0;
        end else if (strobe_in) begin
            if (bit_cnt_q == CW'(F - 1)) begin
                bit_cnt_d  = '0;
                shreg_d    = '0;
                d_out_d    = data_c;
                d_valid_d  = 1'b1;
                syndrome_d = syn_c;
                err_corr_d = corr_c;
                err_det_d  = det_c;
                if (corr_c && (err_count_q != {CNT_W{1'b1}})) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CW'(1);
                shreg_d   = {shreg_q[SW-2:0], d_in};
            end
        end

        busy_d = (bit_cnt_d != '0);
    end

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            d_out_q     <= '0;
            d_valid_q   <= 1'b0;
            syndrome_q  <= '0;
            err_corr_q  <= 1'b0;
            err_det_q   <= 1'b0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            d_out_q     <= d_out_d;
            d_valid_q   <= d_valid_d;
            syndrome_q  <= syndrome_d;
            err_corr_q  <= err_corr_d;
            err_det_q   <= err_det_d;
            err_count_q <= err_count_d;
            busy_q      <= busy_d;
        end
    end

    assign d_out     = d_out_q;
    assign d_valid   = d_valid_q;
    assign syndrome  = syndrome_q;
    assign err_corr  = err_corr_q;
    assign err_det   = err_det_q;
    assign err_count = err_count_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_hamming_serial_rx
//
// Scoreboard bench for hamming_serial_rx. Two instances: P=3 with a 2-bit
// error counter (saturation) and P=4 with an 8-bit counter. Expected results
// are queued as frames are driven and compared on each d_valid.
// -----------------------------------------------------------------------------
module tb_hamming_serial_rx;

`ifdef HAMM_SECDED_EN
    localparam bit SD = 1'b1;
`else
    localparam bit SD = 1'b0;
`endif
    localparam int F3 = SD ? 8 : 7;

    typedef struct packed {
        logic [15:0] d;
        logic [5:0]  syn;
        logic        corr;
        logic        det;
        logic [7:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // P=3 instance
    logic        rst3, d3, stb3, sync3;
    logic [3:0]  d_out3;
    logic        dv3, corr3, det3, busy3;
    logic [2:0]  syn3;
    logic [1:0]  cnt3;

    // P=4 instance
    logic        rst4, d4, stb4, sync4;
    logic [10:0] d_out4;
    logic        dv4, corr4, det4, busy4;
    logic [3:0]  syn4;
    logic [7:0]  cnt4;

    hamming_serial_rx #(.P(3), .CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst3), .d_in(d3), .strobe_in(stb3), .sync_in(sync3),
        .d_out(d_out3), .d_valid(dv3), .syndrome(syn3), .err_corr(corr3),
        .err_det(det3), .err_count(cnt3), .busy(busy3)
    );

    hamming_serial_rx #(.P(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst4), .d_in(d4), .strobe_in(stb4), .sync_in(sync4),
        .d_out(d_out4), .d_valid(dv4), .syndrome(syn4), .err_corr(corr4),
        .err_det(det4), .err_count(cnt4), .busy(busy4)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q3[$];
    exp_t q4[$];
    int   vt3[$];
    int   exp_cnt3 = 0;
    int   exp_cnt4 = 0;
    int   npush3 = 0, npush4 = 0;
    int   nvalid3 = 0, nvalid4 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference Hamming encoder: data MSB into the lowest data position.
    function automatic logic [63:0] encode(input int n, input int k, input logic [63:0] data);
        logic [63:0] cw;
        logic        x;
        int          j;
        cw = '0;
        j  = k;
        for (int p = 1; p <= n; p++) begin
            if ((p & (p - 1)) != 0) begin
                j     = j - 1;
                cw[p] = data[j];
            end
        end
        for (int b = 1; b <= n; b = b * 2) begin
            x = 1'b0;
            for (int q = 1; q <= n; q++) begin
                if (((q & b) != 0) && (q != b)) x = x ^ cw[q];
            end
            cw[b] = x;
        end
        return cw;
    endfunction

    task automatic push3(input logic [15:0] d, input logic [5:0] s, input logic c, input logic dt);
        exp_t e;
        if (c && exp_cnt3 < 3) exp_cnt3++;
        e.d = d; e.syn = s; e.corr = c; e.det = dt; e.cnt = 8'(exp_cnt3);
        q3.push_back(e);
        npush3++;
    endtask

    task automatic push4(input logic [15:0] d, input logic [5:0] s, input logic c, input logic dt);
        exp_t e;
        if (c && exp_cnt4 < 255) exp_cnt4++;
        e.d = d; e.syn = s; e.corr = c; e.det = dt; e.cnt = 8'(exp_cnt4);
        q4.push_back(e);
        npush4++;
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        exp_t e;
        if (dv3) begin
            nvalid3++;
            vt3.push_back(cyc);
            check("expected_entry3", 64'(q3.size() != 0), 64'd1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                check("d_out3",    64'(d_out3), 64'(e.d[3:0]));
                check("syndrome3", 64'(syn3),   64'(e.syn[2:0]));
                check("err_corr3", 64'(corr3),  64'(e.corr));
                check("err_det3",  64'(det3),   64'(e.det));
                check("err_cnt3",  64'(cnt3),   64'(e.cnt[1:0]));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (dv4) begin
            nvalid4++;
            check("expected_entry4", 64'(q4.size() != 0), 64'd1);
            if (q4.size() != 0) begin
                e = q4.pop_front();
                check("d_out4",    64'(d_out4), 64'(e.d[10:0]));
                check("syndrome4", 64'(syn4),   64'(e.syn[3:0]));
                check("err_corr4", 64'(corr4),  64'(e.corr));
                check("err_det4",  64'(det4),   64'(e.det));
                check("err_cnt4",  64'(cnt4),   64'(e.cnt));
            end
        end
    end

    task automatic drive3(input logic b, input logic s);
        @(negedge clk);
        d3 = b; stb3 = 1'b1; sync3 = s;
    endtask

    task automatic idle3();
        @(negedge clk);
        d3 = 1'b0; stb3 = 1'b0; sync3 = 1'b0;
    endtask

    task automatic drive4(input logic b);
        @(negedge clk);
        d4 = b; stb4 = 1'b1; sync4 = 1'b0;
    endtask

    task automatic idle4();
        @(negedge clk);
        d4 = 1'b0; stb4 = 1'b0; sync4 = 1'b0;
    endtask

    // seq[6] is position 1; pbit is the overall parity bit when SECDED.
    task automatic send3(input logic [6:0] seq, input logic pbit, input bit gaps);
        for (int i = 6; i >= 0; i--) begin
            drive3(seq[i], 1'b0);
            if (gaps && (i % 2 == 1)) idle3();
        end
        if (SD) drive3(pbit, 1'b0);
    endtask

    task automatic send4(input logic [63:0] cw, input logic pbit);
        for (int p = 1; p <= 15; p++) drive4(cw[p]);
        if (SD) drive4(pbit);
    endtask

    task automatic drain3();
        for (int i = 0; i < 40 && q3.size() != 0; i++) @(negedge clk);
        check("drain3", 64'(q3.size()), 64'd0);
    endtask

    task automatic drain4();
        for (int i = 0; i < 60 && q4.size() != 0; i++) @(negedge clk);
        check("drain4", 64'(q4.size()), 64'd0);
    endtask

    localparam logic [6:0] CLEAN = 7'b0110011;
    localparam logic [6:0] SERR5 = 7'b0110111;
    localparam logic [6:0] DERR  = 7'b0010001;

    initial begin
        int          nv;
        logic [63:0] cw;
        logic        pb;
        logic [6:0]  clean;

        clean = CLEAN;
        rst3 = 1'b1; d3 = 1'b0; stb3 = 1'b0; sync3 = 1'b0;
        rst4 = 1'b1; d4 = 1'b0; stb4 = 1'b0; sync4 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_d_out3",   64'(d_out3), 64'd0);
        check("rst_valid3",   64'(dv3),    64'd0);
        check("rst_syn3",     64'(syn3),   64'd0);
        check("rst_corr3",    64'(corr3),  64'd0);
        check("rst_det3",     64'(det3),   64'd0);
        check("rst_cnt3",     64'(cnt3),   64'd0);
        check("rst_busy3",    64'(busy3),  64'd0);
        check("rst_d_out4",   64'(d_out4), 64'd0);
        check("rst_cnt4",     64'(cnt4),   64'd0);
        rst3 = 1'b0; rst4 = 1'b0;

        // Clean frame and exact pulse timing
        push3(16'hB, 6'd0, 1'b0, 1'b0);
        send3(CLEAN, 1'b0, 1'b0);
        idle3();
        check("clean_valid_hi", 64'(dv3),   64'd1);
        check("clean_busy",     64'(busy3), 64'd0);
        idle3();
        check("clean_valid_lo", 64'(dv3),    64'd0);
        check("clean_hold",     64'(d_out3), 64'hB);
        drain3();

        // Single error at position 5
        push3(16'hB, 6'd5, 1'b1, 1'b0);
        send3(SERR5, 1'b0, 1'b0);
        idle3();
        drain3();
        check("serr_count", 64'(cnt3), 64'd1);

        // Double error: detected with SECDED, silently miscorrected otherwise
        if (SD) push3(16'h9, 6'd4, 1'b0, 1'b1);
        else    push3(16'h9, 6'd4, 1'b1, 1'b0);
        send3(DERR, 1'b0, 1'b0);
        idle3();
        drain3();
        check("derr_count", 64'(cnt3), 64'(exp_cnt3));

        // Resync mid-frame, then clean frame with strobe gaps
        nv = nvalid3;
        drive3(1'b1, 1'b0); drive3(1'b1, 1'b0); drive3(1'b1, 1'b0);
        idle3();
        check("partial_busy", 64'(busy3), 64'd1);
        push3(16'hB, 6'd0, 1'b0, 1'b0);
        drive3(clean[6], 1'b1);
        for (int i = 5; i >= 0; i--) begin
            drive3(clean[i], 1'b0);
            if (i == 3) begin
                idle3();
                check("gap_busy", 64'(busy3), 64'd1);
            end
        end
        if (SD) drive3(1'b0, 1'b0);
        idle3();
        drain3();
        repeat (3) idle3();
        check("resync_one_valid", 64'(nvalid3 - nv), 64'd1);
        check("resync_d_out",     64'(d_out3),       64'hB);
        check("resync_busy",      64'(busy3),        64'd0);

        // Sync coinciding with a completing strobe: no decode, new frame begins
        nv = nvalid3;
        for (int i = 6; i >= (SD ? 0 : 1); i--) drive3(clean[i], 1'b0);
        push3(16'hB, 6'd0, 1'b0, 1'b0);
        drive3(clean[6], 1'b1);
        for (int i = 5; i >= 0; i--) drive3(clean[i], 1'b0);
        if (SD) drive3(1'b0, 1'b0);
        idle3();
        drain3();
        repeat (3) idle3();
        check("sync_prio_one_valid", 64'(nvalid3 - nv), 64'd1);

        // Saturation with back-to-back frames
        @(negedge clk); rst3 = 1'b1;
        @(negedge clk); rst3 = 1'b0;
        exp_cnt3 = 0;
        vt3.delete();
        for (int f = 0; f < 5; f++) begin
            push3(16'hB, 6'd5, 1'b1, 1'b0);
            send3(SERR5, 1'b0, 1'b0);
        end
        idle3();
        drain3();
        check("b2b_pulses", 64'(vt3.size()), 64'd5);
        for (int i = 1; i < vt3.size(); i++) begin
            check("b2b_spacing", 64'(vt3[i] - vt3[i-1]), 64'(F3));
        end
        check("sat_count", 64'(cnt3), 64'd3);

        // Reset mid-frame overrides strobe and sync
        drive3(1'b0, 1'b0); drive3(1'b1, 1'b0); drive3(1'b1, 1'b0); drive3(1'b0, 1'b0);
        idle3();
        check("mid_busy", 64'(busy3), 64'd1);
        @(negedge clk);
        rst3 = 1'b1; stb3 = 1'b1; d3 = 1'b1; sync3 = 1'b1;
        @(negedge clk);
        check("mrst_d_out", 64'(d_out3), 64'd0);
        check("mrst_valid", 64'(dv3),    64'd0);
        check("mrst_syn",   64'(syn3),   64'd0);
        check("mrst_corr",  64'(corr3),  64'd0);
        check("mrst_det",   64'(det3),   64'd0);
        check("mrst_cnt",   64'(cnt3),   64'd0);
        check("mrst_busy",  64'(busy3),  64'd0);
        rst3 = 1'b0; stb3 = 1'b0; sync3 = 1'b0; d3 = 1'b0;
        exp_cnt3 = 0;
        push3(16'hB, 6'd0, 1'b0, 1'b0);
        send3(CLEAN, 1'b0, 1'b0);
        idle3();
        drain3();

        // P=4: data 11'h5A3 with position 9 flipped
        cw = encode(15, 11, 64'h5A3);
        pb = ^cw[15:1];
        cw[9] = ~cw[9];
        push4(16'h5A3, 6'd9, 1'b1, 1'b0);
        send4(cw, pb);
        idle4();
        drain4();

        // P=4 clean frame
        cw = encode(15, 11, 64'h2C7);
        pb = ^cw[15:1];
        push4(16'h2C7, 6'd0, 1'b0, 1'b0);
        send4(cw, pb);
        idle4();
        drain4();

        repeat (3) @(negedge clk);
        check("total_valid3", 64'(nvalid3), 64'(npush3));
        check("total_valid4", 64'(nvalid4), 64'(npush4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
